keypad_number_entry: RTL and testbench

- Sits between keypad_peripheral and display_peripheral.
- Turns debounced single-key events into a signed 32-bit decimal operand.
- Drives the display with the live entry value and latches a committed value on Enter.
- Supports digit append, sign toggle, clear, Enter, and multi-cycle backspace (sequential divide-by-10).

---
 rtl/keypad_number_entry.sv | 172 +++++++++++++++++
 tb/tb_keypad_number_entry.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_number_entry.sv
// Keypad number entry: turns debounced key events into a signed 32-bit operand,
// with digit append, negate, clear, enter and a bit-serial divide-by-10 backspace.
module keypad_number_entry #(
    parameter int unsigned MAX_DIGITS = 10,
    parameter logic [31:0] MAX_MAG    = 32'h7FFF_FFFF,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [31:0] value,
    output logic [31:0] committed,
    output logic        commit_strobe,
    output logic        busy,
    output logic        err,
    output logic [3:0]  digit_count
);

    localparam int unsigned IterW = $clog2(DIV_CYCLES);

    typedef enum logic [1:0] {StEmpty, StEntry, StDiv, StDone} state_e;

    state_e           state_q, state_d;
    logic [31:0]      mag_q, mag_d;
    logic             neg_q, neg_d;
    logic [3:0]       count_q, count_d;
    logic             err_q, err_d;
    logic [31:0]      committed_q, committed_d;
    logic             strobe_q, strobe_d;
    logic [31:0]      quo_q, quo_d;
    logic [3:0]       rem_q, rem_d;
    logic [IterW-1:0] iter_q, iter_d;

    logic [31:0] value_int;
    logic [35:0] prod;
    logic [4:0]  cnt_inc;
    logic        digit_ok;
    logic [4:0]  div_trial;
    logic        div_ge;
    logic [3:0]  div_rem;
    logic [31:0] quo_next;
    logic        iter_last;

    // -0 wraps to 0, so a cleared magnitude always displays as zero.
    assign value_int = neg_q ? (32'd0 - mag_q) : mag_q;

    assign prod     = ({4'b0, mag_q} << 3) + ({4'b0, mag_q} << 1) + {32'b0, key_code};
    assign cnt_inc  = (mag_q == 32'd0 && key_code == 4'd0) ? {1'b0, count_q}
                                                           : {1'b0, count_q} + 5'd1;
    assign digit_ok = (prod <= {4'b0, MAX_MAG}) && (cnt_inc <= 5'(MAX_DIGITS));

    // Restoring divide-by-10: dividend shifts out MSB-first, quotient shifts in LSB-first.
    assign div_trial = {rem_q, quo_q[31]};
    assign div_ge    = div_trial >= 5'd10;
    assign div_rem   = div_ge ? 4'(div_trial - 5'd10) : div_trial[3:0];
    assign quo_next  = {quo_q[30:0], div_ge};
    assign iter_last = iter_q == IterW'(DIV_CYCLES - 1);

    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        neg_d       = neg_q;
        count_d     = count_q;
        err_d       = err_q;
        committed_d = committed_q;
        strobe_d    = 1'b0;
        quo_d       = quo_q;
        rem_d       = rem_q;
        iter_d      = iter_q;

        if (state_q == StDiv) begin
            quo_d  = quo_next;
            rem_d  = div_rem;
            iter_d = iter_q + 1'b1;
            // 0xE/0xF stay ignored even while dividing.
            if (key_valid && key_code < 4'hE) err_d = 1'b1;
            if (iter_last) begin
                mag_d   = quo_next;
                count_d = count_q - 4'd1;
                if (count_q == 4'd1) begin
                    neg_d   = 1'b0;
                    state_d = StEmpty;
                end else begin
                    state_d = StEntry;
                end
            end
        end else if (key_valid) begin
            if (key_code <= 4'h9) begin
                if (state_q == StDone) begin
                    mag_d   = {28'b0, key_code};
                    neg_d   = 1'b0;
                    count_d = (key_code != 4'd0) ? 4'd1 : 4'd0;
                    err_d   = 1'b0;
                    state_d = (key_code != 4'd0) ? StEntry : StEmpty;
                end else if (digit_ok) begin
                    mag_d   = prod[31:0];
                    count_d = cnt_inc[3:0];
                    err_d   = 1'b0;
                    state_d = (prod == 36'd0) ? StEmpty : StEntry;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                case (key_code)
                    4'hA: begin
                        neg_d = ~neg_q;
                        err_d = 1'b0;
                        if (state_q == StDone) state_d = StEntry;
                    end
                    4'hB: begin
                        if (count_q != 4'd0) begin
                            state_d = StDiv;
                            quo_d   = mag_q;
                            rem_d   = 4'd0;
                            iter_d  = '0;
                            err_d   = 1'b0;
                        end
                    end
                    4'hC: begin
                        mag_d   = 32'd0;
                        neg_d   = 1'b0;
                        count_d = 4'd0;
                        err_d   = 1'b0;
                        state_d = StEmpty;
                    end
                    4'hD: begin
                        committed_d = value_int;
                        strobe_d    = 1'b1;
                        err_d       = 1'b0;
                        state_d     = StDone;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            mag_q       <= 32'd0;
            neg_q       <= 1'b0;
            count_q     <= 4'd0;
            err_q       <= 1'b0;
            committed_q <= 32'd0;
            strobe_q    <= 1'b0;
            quo_q       <= 32'd0;
            rem_q       <= 4'd0;
            iter_q      <= '0;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            neg_q       <= neg_d;
            count_q     <= count_d;
            err_q       <= err_d;
            committed_q <= committed_d;
            strobe_q    <= strobe_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            iter_q      <= iter_d;
        end
    end

    assign value         = value_int;
    assign committed     = committed_q;
    assign commit_strobe = strobe_q;
    assign busy          = state_q == StDiv;
    assign err           = err_q;
    assign digit_count   = count_q;

endmodule

// File: tb/tb_keypad_number_entry.sv
// Scoreboard bench for keypad_number_entry: stimulus queues expected states and
// commits; a negedge monitor pops and compares whenever the DUT settles a result.
module tb_keypad_number_entry;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic [31:0] value;
    logic [31:0] committed;
    logic        commit_strobe;
    logic        busy;
    logic        err;
    logic [3:0]  digit_count;

    keypad_number_entry dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .value         (value),
        .committed     (committed),
        .commit_strobe (commit_strobe),
        .busy          (busy),
        .err           (err),
        .digit_count   (digit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] v;
        logic [3:0]  c;
        logic        e;
        logic [31:0] cm;
    } exp_t;

    exp_t        sq[$];
    logic [31:0] cq[$];
    int          tests = 0;
    int          fails = 0;

    logic kv_e = 1'b0;
    logic rst_e = 1'b0;
    logic busy_b = 1'b0;
    int   bcnt = 0;

    always @(posedge clk) begin
        kv_e   <= key_valid;
        rst_e  <= !rst_n;
        busy_b <= busy;
    end

    // Monitor: a result is presented after reset, after a key that did not start
    // or land in a division, and on the edge busy falls.
    always @(negedge clk) begin
        exp_t        x;
        logic [31:0] w;
        logic        fell;
        fell = (busy_b === 1'b1) && (busy === 1'b0);
        if (commit_strobe === 1'b1) begin
            tests++;
            if (cq.size() == 0) begin
                fails++;
                $display("FAIL commit_unexpected: strobe with committed=%h, none required",
                         committed);
            end else begin
                w = cq.pop_front();
                if (committed !== w) begin
                    fails++;
                    $display("FAIL commit_value: got %h, required %h", committed, w);
                end
            end
        end
        if (busy === 1'b1) bcnt++;
        if (rst_e || fell || (kv_e && busy === 1'b0)) begin
            if (!rst_e && fell) begin
                tests++;
                if (bcnt != 32) begin
                    fails++;
                    $display("FAIL busy_len: got %0d cycles, required 32", bcnt);
                end
            end
            tests++;
            if (sq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_result: value=%h count=%0d err=%b, none required",
                         value, digit_count, err);
            end else begin
                x = sq.pop_front();
                if (value !== x.v || digit_count !== x.c || err !== x.e || committed !== x.cm)
                begin
                    fails++;
                    $display("FAIL %s: got value=%h count=%0d err=%b committed=%h, required value=%h count=%0d err=%b committed=%h",
                             x.nm, value, digit_count, err, committed, x.v, x.c, x.e, x.cm);
                end
            end
        end
        if (busy !== 1'b1) bcnt = 0;
    end

    task automatic send(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic press(input logic [3:0] k, input string nm, input logic [31:0] v,
                         input logic [3:0] c, input logic e, input logic [31:0] cm);
        exp_t x;
        x = '{nm, v, c, e, cm};
        sq.push_back(x);
        if (k == 4'hD) cq.push_back(cm);
        send(k);
    endtask

    task automatic push_reset();
        exp_t x;
        x = '{"reset", 32'd0, 4'd0, 1'b0, 32'd0};
        sq.push_back(x);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        push_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Basic entry, negate, ignored code, clear
        press(4'h1, "d1",     32'd1,         4'd1, 1'b0, 32'd0);
        press(4'h2, "d12",    32'd12,        4'd2, 1'b0, 32'd0);
        press(4'h3, "d123",   32'd123,       4'd3, 1'b0, 32'd0);
        press(4'hA, "neg123", 32'hFFFF_FF85, 4'd3, 1'b0, 32'd0);
        press(4'hE, "ignE",   32'hFFFF_FF85, 4'd3, 1'b0, 32'd0);
        press(4'hC, "clr1",   32'd0,         4'd0, 1'b0, 32'd0);

        // Enter, fresh entry from DONE, re-commit, negate in DONE, enter in EMPTY
        press(4'h1, "e1",      32'd1,         4'd1, 1'b0, 32'd0);
        press(4'h2, "e12",     32'd12,        4'd2, 1'b0, 32'd0);
        press(4'hA, "eneg",    32'hFFFF_FFF4, 4'd2, 1'b0, 32'd0);
        press(4'hD, "enter12", 32'hFFFF_FFF4, 4'd2, 1'b0, 32'hFFFF_FFF4);
        press(4'h5, "fresh5",  32'd5,         4'd1, 1'b0, 32'hFFFF_FFF4);
        press(4'hD, "enter5",  32'd5,         4'd1, 1'b0, 32'd5);
        press(4'hD, "reenter", 32'd5,         4'd1, 1'b0, 32'd5);
        press(4'hA, "doneneg", 32'hFFFF_FFFB, 4'd1, 1'b0, 32'd5);
        press(4'hC, "clr2",    32'd0,         4'd0, 1'b0, 32'd5);
        press(4'hD, "enter0",  32'd0,         4'd0, 1'b0, 32'd0);
        press(4'hC, "clr3",    32'd0,         4'd0, 1'b0, 32'd0);

        // Magnitude limit
        press(4'h2, "m1",  32'd2,          4'd1, 1'b0, 32'd0);
        press(4'h1, "m2",  32'd21,         4'd2, 1'b0, 32'd0);
        press(4'h4, "m3",  32'd214,        4'd3, 1'b0, 32'd0);
        press(4'h7, "m4",  32'd2147,       4'd4, 1'b0, 32'd0);
        press(4'h4, "m5",  32'd21474,      4'd5, 1'b0, 32'd0);
        press(4'h8, "m6",  32'd214748,     4'd6, 1'b0, 32'd0);
        press(4'h3, "m7",  32'd2147483,    4'd7, 1'b0, 32'd0);
        press(4'h6, "m8",  32'd21474836,   4'd8, 1'b0, 32'd0);
        press(4'h4, "m9",  32'd214748364,  4'd9, 1'b0, 32'd0);
        press(4'h8, "ovf", 32'd214748364,  4'd9, 1'b1, 32'd0);
        press(4'h7, "max", 32'h7FFF_FFFF,  4'd10, 1'b0, 32'd0);
        press(4'h1, "ovf2", 32'h7FFF_FFFF, 4'd10, 1'b1, 32'd0);
        press(4'hC, "clr4", 32'd0,         4'd0, 1'b0, 32'd0);

        // Backspace with a key dropped mid-division
        press(4'h4, "b4",   32'd4,   4'd1, 1'b0, 32'd0);
        press(4'h5, "b45",  32'd45,  4'd2, 1'b0, 32'd0);
        press(4'h6, "b456", 32'd456, 4'd3, 1'b0, 32'd0);
        press(4'hB, "bs456_drop", 32'd45, 4'd2, 1'b1, 32'd0);
        repeat (10) @(negedge clk);
        send(4'h9);
        repeat (26) @(negedge clk);
        press(4'hB, "bs45", 32'd4, 4'd1, 1'b0, 32'd0);
        repeat (36) @(negedge clk);
        press(4'hB, "bs4",  32'd0, 4'd0, 1'b0, 32'd0);
        repeat (36) @(negedge clk);
        press(4'hB, "bs_empty", 32'd0, 4'd0, 1'b0, 32'd0);

        // Leading zeros, negative backspace to empty
        press(4'h0, "z1",    32'd0,         4'd0, 1'b0, 32'd0);
        press(4'h0, "z2",    32'd0,         4'd0, 1'b0, 32'd0);
        press(4'h7, "z7",    32'd7,         4'd1, 1'b0, 32'd0);
        press(4'hA, "zneg",  32'hFFFF_FFF9, 4'd1, 1'b0, 32'd0);
        press(4'hB, "bsneg", 32'd0,         4'd0, 1'b0, 32'd0);
        repeat (36) @(negedge clk);
        press(4'h0, "z3",    32'd0,         4'd0, 1'b0, 32'd0);
        press(4'h5, "pos5",  32'd5,         4'd1, 1'b0, 32'd0);
        press(4'hC, "clr5",  32'd0,         4'd0, 1'b0, 32'd0);

        // Reset mid-division
        press(4'h9, "r9",  32'd9,  4'd1, 1'b0, 32'd0);
        press(4'h9, "r99", 32'd99, 4'd2, 1'b0, 32'd0);
        send(4'hB);
        repeat (5) @(negedge clk);
        push_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        press(4'h3, "after_rst", 32'd3, 4'd1, 1'b0, 32'd0);

        repeat (4) @(negedge clk);
        tests++;
        if (sq.size() != 0) begin
            fails++;
            $display("FAIL results_pending: got %0d unchecked, required 0", sq.size());
        end
        tests++;
        if (cq.size() != 0) begin
            fails++;
            $display("FAIL commits_pending: got %0d unseen, required 0", cq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
